// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bus bundle for the instruction fetch front end. It carries
//                the instruction-memory request/response channel, the
//                decoder redirect and the decoded head instruction.
//                master = fetch unit, slave = memory + decoder side.
//  Ports       : imem_req_valid/ready/addr, imem_rsp_valid/data,
//                pc_src/pc_target, instr_valid/ready, instr, instr_pc,
//                op, funct3, funct7
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  pc_src, pc_target,
        output instr_valid, instr, instr_pc, op, funct3, funct7,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output pc_src, pc_target,
        input  instr_valid, instr, instr_pc, op, funct3, funct7,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch front end. Issues sequential word fetches
//                under a credit limit of DEPTH (in flight + buffered), keeps
//                in-order responses in a small FIFO and presents the head word
//                with its PC and op/funct3/funct7 fields. A redirect clears
//                the FIFO and discards every response still outstanding.
//  Ports       : clk, rst_n (async, active low)
//                bus (instr_fetch_if.master): memory request/response,
//                redirect input, head instruction output
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int              c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] c_NOP      = XLEN'(32'h0000_0013);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_CREDIT = (c_CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_CNT_W-1:0]   inflight_q, inflight_d;
    logic [c_CNT_W-1:0]   drop_q, drop_d;
    logic [XLEN-1:0]      data_q [DEPTH];
    logic [XLEN-1:0]      pc_q   [DEPTH];

    logic                 w_req_valid;
    logic                 w_accept;
    logic                 w_rsp_fire;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_valid;
    logic [XLEN-1:0]      w_rsp_pc;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_head_valid = (count_q != '0);

    // Requests go out to consecutive addresses, so the oldest outstanding
    // request (the one this response answers) sits inflight*4 below fetch_pc.
    assign w_rsp_pc = fetch_pc_q - {{(XLEN-c_CNT_W-2){1'b0}}, inflight_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        drop_d      = drop_q;
        w_req_valid = 1'b0;
        w_push      = 1'b0;
        // A response with nothing outstanding is a protocol error and ignored.
        w_rsp_fire  = bus.imem_rsp_valid && (inflight_q != '0);
        w_pop       = w_head_valid && bus.instr_ready;

        unique case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN: begin
                w_req_valid = (({1'b0, inflight_q} + {1'b0, count_q}) < c_CREDIT)
                              && !bus.pc_src;
                w_push      = w_rsp_fire && !bus.pc_src;
            end
            S_FLUSH: begin
                drop_d = drop_q - c_CNT_W'(w_rsp_fire);
                if (drop_d == '0) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        w_accept   = w_req_valid && bus.imem_req_ready;
        inflight_d = inflight_q + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp_fire);
        if (w_accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        // Redirect overrides everything: no request went out this cycle, so
        // every outstanding request (less the one answered now) must be dropped.
        if (bus.pc_src && (state_q != S_IDLE)) begin
            fetch_pc_d = {bus.pc_target[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_d     = inflight_q - c_CNT_W'(w_rsp_fire);
            state_d    = (drop_d != '0) ? S_FLUSH : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer storage needs no reset: it is only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            data_q[wr_ptr_q] <= bus.imem_rsp_data;
            pc_q[wr_ptr_q]   <= w_rsp_pc;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = w_head_valid;
    assign bus.instr          = w_head_valid ? data_q[rd_ptr_q] : c_NOP;
    assign bus.instr_pc       = w_head_valid ? pc_q[rd_ptr_q]   : fetch_pc_q;
    assign bus.op             = bus.instr[6:0];
    assign bus.funct3         = bus.instr[14:12];
    assign bus.funct7         = bus.instr[31:25];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A memory model answers
//                requests in order with random latency; the reference model is
//                the program-order stream of PCs (sequential, re-targeted by
//                each redirect) that the decoder must see.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    instr_fetch_if #(.XLEN(32)) bus ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n_acc  = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    req_t        mq[$];
    logic [31:0] exp_pc, exp_req, h_addr;
    logic        h_pend;
    logic        s_req_valid, s_ivalid, s_fire, s_pop;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [6:0]  s_op, s_f7;
    logic [2:0]  s_f3;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0040_0093;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_pc  = 32'h0;
        exp_req = 32'h0;
        h_pend  = 1'b0;
        bus.imem_rsp_valid = 1'b0;
    endtask

    // One clock: sample at negedge, check against the model, then drive the
    // memory response for the next cycle just after the rising edge.
    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        s_req_valid = bus.imem_req_valid;
        s_addr      = bus.imem_req_addr;
        s_ivalid    = bus.instr_valid;
        s_instr     = bus.instr;
        s_pc        = bus.instr_pc;
        s_op        = bus.op;
        s_f3        = bus.funct3;
        s_f7        = bus.funct7;
        s_fire      = s_req_valid && bus.imem_req_ready;
        s_pop       = s_ivalid && bus.instr_ready;

        if (h_pend && !bus.pc_src) begin
            chk("req_hold_valid", {31'b0, s_req_valid}, 32'd1);
            chk("req_hold_addr", s_addr, h_addr);
        end
        if (s_pop) begin
            w = mem_word(exp_pc);
            chk("pop_pc", s_pc, exp_pc);
            chk("pop_instr", s_instr, w);
            chk("pop_op", {25'b0, s_op}, {25'b0, w[6:0]});
            chk("pop_funct3", {29'b0, s_f3}, {29'b0, w[14:12]});
            chk("pop_funct7", {25'b0, s_f7}, {25'b0, w[31:25]});
            exp_pc = exp_pc + 32'd4;
        end
        if (!s_ivalid) chk("empty_nop", s_instr, c_NOP);
        if (bus.pc_src) chk("no_req_on_redirect", {31'b0, s_req_valid}, 32'd0);
        if (s_req_valid) chk("req_addr", s_addr, exp_req);
        if (s_fire) begin
            mq.push_back('{addr: s_addr,
                           due: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
            exp_req = exp_req + 32'd4;
            n_acc++;
        end
        if (bus.imem_rsp_valid) mq.delete(0);
        if (bus.pc_src) begin
            exp_pc  = bus.pc_target & ~32'd3;
            exp_req = bus.pc_target & ~32'd3;
        end
        h_pend = s_req_valid && !bus.imem_req_ready && !bus.pc_src;
        h_addr = s_addr;

        @(posedge clk);
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
    endtask

    task automatic rand_inputs(input bit allow_redirect);
        bus.imem_req_ready = ($urandom_range(3, 0) != 0);
        bus.instr_ready    = ($urandom_range(3, 0) != 0);
        bus.pc_src         = allow_redirect && ($urandom_range(23, 0) == 0);
        bus.pc_target      = $urandom;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.pc_src         = 1'b0;
        bus.pc_target      = '0;
        bus.instr_ready    = 1'b0;
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, c_NOP);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);

        // Release: 1-cycle memory, decoder stalled -> latency and credit limit
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("first_valid_latency", {31'b0, s_ivalid}, (i >= 3) ? 32'd1 : 32'd0);
            if (i == 3) begin
                chk("head_instr", s_instr, 32'h0040_0093);
                chk("head_op", {25'b0, s_op}, 32'h13);
                chk("head_funct3", {29'b0, s_f3}, 32'h0);
                chk("head_funct7", {25'b0, s_f7}, 32'h0);
                chk("head_pc", s_pc, 32'h0);
            end
        end
        chk("stall_req_count", n_acc, 32'd2);
        chk("stall_req_valid", {31'b0, s_req_valid}, 32'd0);

        // Redirect with two requests in flight
        lat_min = 4;
        lat_max = 4;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 20 && mq.size() != 2; i++) step();
        chk("setup_inflight", mq.size(), 32'd2);
        bus.pc_src    = 1'b1;
        bus.pc_target = 32'h0000_0102;
        step();
        bus.pc_src = 1'b0;
        lat_min = 1;
        lat_max = 1;
        s_fire = 1'b0;
        for (int i = 0; i < 20 && !s_fire; i++) step();
        chk("redirect_req_seen", {31'b0, s_fire}, 32'd1);
        chk("redirect_req_addr", s_addr, 32'h0000_0100);
        s_pop = 1'b0;
        for (int i = 0; i < 20 && !s_pop; i++) step();
        chk("redirect_pop_seen", {31'b0, s_pop}, 32'd1);
        chk("redirect_pop_pc", s_pc, 32'h0000_0100);

        // Redirect to the top of the address space -> wrap
        bus.pc_src    = 1'b1;
        bus.pc_target = 32'hFFFF_FFFC;
        step();
        bus.pc_src = 1'b0;
        s_fire = 1'b0;
        for (int i = 0; i < 20 && !s_fire; i++) step();
        chk("wrap_req0", s_addr, 32'hFFFF_FFFC);
        s_fire = 1'b0;
        for (int i = 0; i < 20 && !s_fire; i++) step();
        chk("wrap_req1", s_addr, 32'h0000_0000);

        // Random traffic with random latency and redirects
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            rand_inputs(1'b1);
            step();
        end

        // Reset in the middle of a burst with the buffer occupied
        bus.pc_src = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_req_ready = 1'b1;
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 6; i++) step();
        chk("midburst_valid_before", {31'b0, s_ivalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("mid_rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("mid_rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("mid_rst_instr", bus.instr, c_NOP);
        chk("mid_rst_instr_pc", bus.instr_pc, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_hold_valid", {31'b0, bus.instr_valid}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Recovery after reset: back to sequential fetch from address 0
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 300; i++) begin
            rand_inputs(i >= 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
